// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: FSM states, register offsets, STATUS bit positions and DIVISOR floor for uart_tx_port
package uart_tx_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  localparam logic [1:0] A_DATA = 2'd0, A_STATUS = 2'd1, A_DIV = 2'd2, A_IRQEN = 2'd3;
  localparam int ST_FULL = 0, ST_EMPTY = 1, ST_BUSY = 2, ST_OVF = 3, ST_CNT = 8;
  localparam logic [15:0] DIV_MIN = 16'd2;
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign w_pop = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data = r_mem[r_rd];
  // storage array, written only on an accepted push
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: bus-mapped 8N1 UART transmitter with TX FIFO; define UART_TX_IRQ_EN for the IRQEN register and irq
import uart_tx_pkg::*;
module uart_tx_port #(
  parameter logic [15:0] CLK_DIV = 16'd104,
  parameter int FIFO_DEPTH = 8,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busValid,
  input  logic        busWrite,
  input  logic [1:0]  busAddress,
  input  logic [31:0] busWriteData,
  output logic [31:0] busReadData,
  output logic        busReady,
  output logic        txd,
  output logic        irq
);
  state_t r_state;
  logic [15:0] r_div, r_frame_div, r_tmr;
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic r_txd, r_ovf;
  logic w_req_wr, w_push, w_pop, w_full, w_empty, w_busy, w_tick, w_rd_status, w_unused;
  logic [7:0] w_fifo_data;
  logic [CW-1:0] w_count;
  logic [31:0] w_status, w_rdata, w_irqen_rd;
  assign w_req_wr = busValid && busWrite;
  assign w_push = w_req_wr && busAddress == A_DATA;
  assign w_rd_status = busValid && !busWrite && busAddress == A_STATUS;
  assign w_busy = r_state != S_IDLE;
  assign w_tick = r_tmr == '0;
  assign w_pop = !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_tick));
  assign w_unused = ^busWriteData[31:16];
  assign txd = r_txd;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .i_push(w_push),
    .i_data(busWriteData[7:0]),
    .i_pop(w_pop),
    .o_data(w_fifo_data),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );
  // STATUS word and read mux
  always_comb begin
    w_status = '0;
    w_status[ST_FULL] = w_full;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_BUSY] = w_busy;
    w_status[ST_OVF] = r_ovf;
    w_status[ST_CNT +: 4] = 4'(w_count);
    w_rdata = busAddress == A_STATUS ? w_status :
              busAddress == A_DIV    ? {16'b0, r_div} :
              busAddress == A_IRQEN  ? w_irqen_rd : '0;
  end
  // bus acknowledge, readback, divisor and sticky overflow (set by a dropped byte, cleared by STATUS read)
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      busReady <= 1'b0;
      busReadData <= '0;
      r_div <= CLK_DIV;
      r_ovf <= 1'b0;
    end else begin
      busReady <= busValid;
      busReadData <= (busValid && !busWrite) ? w_rdata : '0;
      if (w_req_wr && busAddress == A_DIV) r_div <= clamp_div(busWriteData[15:0]);
      r_ovf <= (w_push && w_full && !w_pop) ? 1'b1 : (w_rd_status ? 1'b0 : r_ovf);
    end
  // serialiser: the divisor is latched per frame so mid-frame DIVISOR writes wait for the next start
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_tmr <= '0;
      r_frame_div <= CLK_DIV;
      r_shift <= '0;
      r_bit <= '0;
      r_txd <= 1'b1;
    end else if (w_pop) begin
      r_state <= S_START;
      r_tmr <= r_div - 16'd1;
      r_frame_div <= r_div;
      r_shift <= w_fifo_data;
      r_txd <= 1'b0;
    end else if (r_state != S_IDLE) begin
      r_tmr <= w_tick ? r_frame_div - 16'd1 : r_tmr - 16'd1;
      if (w_tick) begin
        case (r_state)
          S_START, S_DATA: begin
            r_state <= (r_state == S_DATA && r_bit == 3'd7) ? S_STOP : S_DATA;
            r_txd <= (r_state == S_DATA && r_bit == 3'd7) ? 1'b1 : r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit <= r_state == S_START ? 3'd0 : r_bit + 3'd1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
`ifdef UART_TX_IRQ_EN
  logic [1:0] r_irqen;
  logic r_irq;
  // IRQEN register and registered level interrupt
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_irqen <= '0;
      r_irq <= 1'b0;
    end else begin
      if (w_req_wr && busAddress == A_IRQEN) r_irqen <= busWriteData[1:0];
      r_irq <= (r_irqen[0] && w_empty && !w_busy) || (r_irqen[1] && r_ovf);
    end
  assign w_irqen_rd = {30'b0, r_irqen};
  assign irq = r_irq;
`else
  assign w_irqen_rd = '0;
  assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: scoreboard bench for uart_tx_port (bus readback queue plus serial frame decoder)
module tb_uart_tx_port;
  logic clk = 1'b0, reset = 1'b1, busValid = 1'b0, busWrite = 1'b0;
  logic [1:0] busAddress = '0;
  logic [31:0] busWriteData = '0;
  logic [31:0] busReadData;
  logic busReady, txd, irq;
`ifdef UART_TX_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  uart_tx_port dut (
    .clk(clk),
    .reset(reset),
    .busValid(busValid),
    .busWrite(busWrite),
    .busAddress(busAddress),
    .busWriteData(busWriteData),
    .busReadData(busReadData),
    .busReady(busReady),
    .txd(txd),
    .irq(irq)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0, cyc = 0, cur_div = 104;
  bit sb_chk[$];
  logic [31:0] sb_exp[$];
  string sb_name[$];
  logic [7:0] txq[$];
  int starts[$];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic req(input bit w, input logic [1:0] a, input logic [31:0] d, input bit chk,
                     input logic [31:0] exp, input string nm);
    busValid = 1'b1;
    busWrite = w;
    busAddress = a;
    busWriteData = d;
    sb_chk.push_back(chk && !w);
    sb_exp.push_back(exp);
    sb_name.push_back(nm);
    if (w && a == 2'd2) cur_div = (d[15:0] < 16'd2) ? 2 : int'(d[15:0]);
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    req(1'b0, a, 32'h0, 1'b1, exp, nm);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    req(1'b1, a, d, 1'b0, 32'h0, "write");
  endtask
  task automatic tx(input logic [7:0] b, input bit acc);
    if (acc) txq.push_back(b);
    wr(2'd0, {24'h0, b});
  endtask
  task automatic idle();
    busValid = 1'b0;
    busWrite = 1'b0;
  endtask
  task automatic drain();
    for (int k = 0; k < 4000 && txq.size() != 0; k++) @(posedge clk);
    if (txq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain timeout: %0d frames still expected", txq.size());
      txq.delete();
    end
    repeat (2 * cur_div + 20) @(posedge clk);
    #1;
  endtask
  task automatic wait_n(input int n, inout bit ab);
    for (int k = 0; k < n; k++) begin
      if (ab) return;
      @(negedge clk);
      if (reset) ab = 1'b1;
    end
  endtask

  // bus monitor: every acknowledge consumes one scoreboard entry
  always @(negedge clk)
    if (busReady) begin
      if (sb_chk.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious ack: got busReady=1 expected no pending request");
      end else begin
        bit c;
        logic [31:0] e;
        string nm;
        c = sb_chk.pop_front();
        e = sb_exp.pop_front();
        nm = sb_name.pop_front();
        if (c) check(nm, busReadData, e);
      end
    end

  // serial decoder: samples mid-bit using the divisor in force when the start edge is seen
  initial begin
    int d;
    bit ab;
    logic [7:0] b;
    logic sb;
    forever begin
      @(negedge clk);
      if (!reset && txd === 1'b0) begin
        d = cur_div;
        ab = 1'b0;
        starts.push_back(cyc);
        wait_n(d / 2, ab);
        if (!ab) check("start bit", {31'b0, txd}, 32'h0);
        for (int i = 0; i < 8; i++) begin
          wait_n(d, ab);
          b[i] = txd;
        end
        wait_n(d, ab);
        sb = txd;
        if (!ab) begin
          check("stop bit", {31'b0, sb}, 32'h1);
          if (txq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected frame: got %h expected none", b);
          end else check("tx byte", {24'b0, b}, {24'b0, txq.pop_front()});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] lv;
    repeat (3) @(posedge clk);
    #1;
    check("rst txd", {31'b0, txd}, 32'h1);
    check("rst busReady", {31'b0, busReady}, 32'h0);
    check("rst busReadData", busReadData, 32'h0);
    check("rst irq", {31'b0, irq}, 32'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    rd(2'd1, 32'h2, "rst status");
    rd(2'd2, 32'd104, "rst divisor");
    rd(2'd3, 32'h0, "rst irqen");
    rd(2'd0, 32'h0, "data read");
    idle();
    // 1: single 0x55 frame with exact bit timing
    wr(2'd2, 32'd4);
    tx(8'h55, 1'b1);
    idle();
    check("t1 txd at E", {31'b0, txd}, 32'h1);
    lv = 10'b1010101010;
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < 4; c++) begin
        @(posedge clk);
        #1;
        check("t1 level", {31'b0, txd}, {31'b0, lv[b]});
      end
    @(posedge clk);
    #1;
    check("t1 txd after", {31'b0, txd}, 32'h1);
    rd(2'd1, 32'h2, "t1 status");
    idle();
    drain();
    // 2: nine back-to-back bytes fill the FIFO, tenth is dropped
    for (int i = 0; i < 9; i++) tx(8'(i), 1'b1);
    rd(2'd1, 32'h805, "t2 status full");
    tx(8'h09, 1'b0);
    rd(2'd1, 32'h80D, "t2 status ovf");
    rd(2'd1, 32'h805, "t2 status ovf cleared");
    idle();
    drain();
    // 3: contiguous frames
    starts.delete();
    tx(8'hA5, 1'b1);
    tx(8'h3C, 1'b1);
    idle();
    drain();
    check("t3 frame gap", (starts.size() == 2) ? 32'(starts[1] - starts[0]) : 32'hFFFF_FFFF, 32'd40);
    // 4: divisor floor and mid-frame change
    wr(2'd2, 32'd0);
    rd(2'd2, 32'd2, "t4 div 0");
    wr(2'd2, 32'd1);
    rd(2'd2, 32'd2, "t4 div 1");
    wr(2'd2, 32'd6);
    tx(8'hC3, 1'b1);
    idle();
    repeat (10) @(posedge clk);
    #1;
    wr(2'd2, 32'd3);
    rd(2'd2, 32'd3, "t4 div 3");
    idle();
    drain();
    tx(8'h81, 1'b1);
    idle();
    drain();
    // 5: reset in the middle of a data bit
    wr(2'd2, 32'd4);
    tx(8'h00, 1'b1);
    idle();
    repeat (5) @(posedge clk);
    #1;
    req(1'b0, 2'd1, 32'h0, 1'b0, 32'h0, "t5 status");
    idle();
    check("t5 txd before reset", {31'b0, txd}, 32'h0);
    check("t5 ack before reset", {31'b0, busReady}, 32'h1);
    #1 reset = 1'b1;
    sb_chk.delete();
    sb_exp.delete();
    sb_name.delete();
    txq.delete();
    #1;
    check("t5 reset txd", {31'b0, txd}, 32'h1);
    check("t5 reset busReady", {31'b0, busReady}, 32'h0);
    check("t5 reset busReadData", busReadData, 32'h0);
    check("t5 reset irq", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cur_div = 104;
    @(posedge clk);
    #1;
    rd(2'd1, 32'h2, "t5 status");
    rd(2'd2, 32'd104, "t5 divisor");
    idle();
    // 6: empty interrupt (stays 0 when the feature is not built)
    wr(2'd2, 32'd4);
    wr(2'd3, 32'h1);
    rd(2'd3, {31'b0, IRQ_ON}, "t6 irqen");
    idle();
    @(posedge clk);
    #1;
    check("t6 irq idle", {31'b0, irq}, {31'b0, IRQ_ON});
    tx(8'h96, 1'b1);
    idle();
    for (int k = 0; k < 41; k++) begin
      @(posedge clk);
      #1;
      check("t6 irq busy", {31'b0, irq}, 32'h0);
    end
    @(posedge clk);
    #1;
    check("t6 irq after idle", {31'b0, irq}, {31'b0, IRQ_ON});
    drain();
    check("ack backlog", 32'(sb_chk.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
